issue_queue: RTL
================

# issue_queue

Parametrised, collapsing issue queue: the multi-entry successor of the single issue slot. It holds up to DEPTH dispatched micro-ops, each with NUM_SRCS tagged source operands, wakes operands from NUM_WAKEUP_PORTS writeback broadcasts, and issues the oldest ready micro-op to one functional-unit port per cycle. It sits between rename/dispatch and the execution pipeline.

## Interface
- DEPTH, 8: number of entries (≥2).
- NUM_SRCS, 2: source operands per micro-op (≥1).
- NUM_WAKEUP_PORTS, 2: wakeup broadcast ports (≥1).
- PREG_W, 7: physical register tag width.
- CTRL_W, 8: opaque control payload width (FU type, opcode, etc.).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch this cycle.
- disp_src_id  in  NUM_SRCS*PREG_W  source tags, src k at bits [k*PREG_W +: PREG_W].
- disp_src_p  in  NUM_SRCS  source k already ready at dispatch.
- disp_src_v  in  NUM_SRCS  source k used by the micro-op.
- disp_pdst  in  PREG_W  destination tag (carried through).
- disp_ctrl  in  CTRL_W  control payload (carried through).
- wakeup_valid  in  NUM_WAKEUP_PORTS  broadcast valid per port.
- wakeup_pdst  in  NUM_WAKEUP_PORTS*PREG_W  broadcast tag per port.
- issue_valid  out  1  a ready micro-op is presented.
- issue_ready  in  1  FU accepts; fire = issue_valid & issue_ready.
- issue_src_id  out  NUM_SRCS*PREG_W  selected entry source tags.
- issue_pdst  out  PREG_W  selected entry destination.
- issue_ctrl  out  CTRL_W  selected entry payload.
- flush  in  1  synchronous kill of all entries.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Entries 0..count-1 valid; index 0 is oldest. Entries are stored compacted, no holes.
- Entry ready when, for every k, v[k]==0 or p[k]==1.
- Select: lowest-index ready entry. issue_valid = any ready entry and !flush. Issue buses carry selected entry; all zero when issue_valid=0.
- On fire: selected entry removed; every entry above it shifts down one index in the same edge; count decrements.
- Wakeup: any port with wakeup_valid and wakeup_pdst==src_id[k] of a valid entry with v[k]=1 sets p[k]. Applied to the entry in its post-shift position. Multiple ports matching same operand: idempotent.
- Dispatch: disp_ready = (count < DEPTH). Accept on disp_valid & disp_ready; written at index count, or count-1 if a fire occurs the same cycle. Captured p[k] = disp_src_p[k] | (same-cycle wakeup match on disp_src_id[k]); a wakeup concurrent with dispatch is never lost.
- Full and firing same cycle: disp_ready stays 0 (no dispatch-through-full).
- flush: next state count=0, all entries invalid; dispatch ignored; issue_valid forced 0 that cycle. Flush has priority over fire, dispatch and wakeup.
- Invalid entries hold don't-care contents but never match wakeups and never select.

## Timing
- Reset (asynchronous, reset=0): count=0, all entries invalid and zeroed; disp_ready=1, issue_valid=0, issue_src_id/issue_pdst/issue_ctrl=0. Reset mid-operation discards all entries immediately.
- Dispatch at edge t: entry visible and, if already ready, issue_valid high in cycle t+1.
- Wakeup in cycle t: entry eligible for issue in cycle t+1 (default build).
- Issue outputs are combinational from queue state; fire removes entry at the same edge. Back-to-back issue of distinct entries every cycle is supported.
- count, disp_ready reflect registered state only (no combinational path from issue_ready or disp_valid).

## Configuration
- ISSUE_QUEUE_BYPASS_EN defined: wakeup matches in cycle t also feed the ready computation for select in cycle t (zero-cycle wakeup-to-issue); the combinational path wakeup_* -> issue_* exists. State update is unchanged.
- Undefined: select uses registered p bits only; wakeup-to-issue latency is one cycle; no wakeup_* -> issue_* path.

## Test plan
- Reset then dispatch op A (srcs 5,6, p=11, v=11, pdst 9) with issue_ready=1 -> issue_valid=1 next cycle with src 5,6/pdst 9, count returns 0.
- Dispatch A (src 3, p=0) then B (ready); -> B issues first, A issues the cycle after wakeup_pdst=3 on port 1 (same cycle with ISSUE_QUEUE_BYPASS_EN).
- Fill 8 entries all not ready -> disp_ready=0, count=8; fire index 2 after wakeup -> entries 3..7 shift to 2..6, count=7, disp_ready=1.
- Dispatch src 12 with p=0 while wakeup_pdst=12 same cycle -> entry ready, issued next cycle without further wakeup.
- Fire and dispatch same cycle with count=4 -> new op lands at index 3, count stays 4.
- Assert flush with count=5 and disp_valid=1 -> issue_valid=0 that cycle, count=0 next cycle, dispatched op dropped.

Source files
------------

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//
// Collapsing issue queue. Holds up to DEPTH dispatched micro-ops in age order
// (index 0 is oldest, valid entries packed at 0..count-1). Source operands are
// woken by writeback broadcasts, and the oldest ready micro-op is presented to
// a single functional-unit port each cycle. When an entry issues, every entry
// above it shifts down by one on the same edge.
//
// Optional feature (compile-time macro):
//   ISSUE_QUEUE_BYPASS_EN - same-cycle wakeup matches also feed select, giving
//                           zero-cycle wakeup-to-issue. State update unchanged.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   disp_valid/ready    dispatch handshake (ready = count < DEPTH, registered)
//   disp_src_id/p/v     per-source tag, ready-at-dispatch bit, used bit
//   disp_pdst/ctrl      destination tag and opaque payload, carried through
//   wakeup_valid/pdst   writeback broadcast per wakeup port
//   issue_valid/ready   issue handshake; fire = issue_valid & issue_ready
//   issue_src_id/pdst/ctrl  selected entry fields, zero when not valid
//   flush               synchronous kill of all entries
//   count               number of valid entries
// -----------------------------------------------------------------------------
module issue_queue #(
  parameter int DEPTH            = 8,
  parameter int NUM_SRCS         = 2,
  parameter int NUM_WAKEUP_PORTS = 2,
  parameter int PREG_W           = 7,
  parameter int CTRL_W           = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [NUM_SRCS*PREG_W-1:0]         disp_src_id,
  input  logic [NUM_SRCS-1:0]                disp_src_p,
  input  logic [NUM_SRCS-1:0]                disp_src_v,
  input  logic [PREG_W-1:0]                  disp_pdst,
  input  logic [CTRL_W-1:0]                  disp_ctrl,
  input  logic [NUM_WAKEUP_PORTS-1:0]        wakeup_valid,
  input  logic [NUM_WAKEUP_PORTS*PREG_W-1:0] wakeup_pdst,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [NUM_SRCS*PREG_W-1:0]         issue_src_id,
  output logic [PREG_W-1:0]                  issue_pdst,
  output logic [CTRL_W-1:0]                  issue_ctrl,
  input  logic                               flush,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [NUM_SRCS-1:0][PREG_W-1:0] src_id;
    logic [NUM_SRCS-1:0]             src_p;
    logic [NUM_SRCS-1:0]             src_v;
    logic [PREG_W-1:0]               pdst;
    logic [CTRL_W-1:0]               ctrl;
  } entry_t;

  entry_t                          q   [DEPTH];
  entry_t                          q_n [DEPTH];
  logic [CNT_W-1:0]                count_n;

  logic [DEPTH-1:0][NUM_SRCS-1:0]  hit;       // stored operand matches a broadcast
  logic [DEPTH-1:0][NUM_SRCS-1:0]  hit_sh;    // hit, realigned to post-shift index
  logic [NUM_SRCS-1:0]             disp_hit;  // dispatching operand matches a broadcast
  logic [DEPTH-1:0]                rdy;
  logic [IDX_W-1:0]                sel;
  logic                            any_rdy;
  logic                            fire;
  logic                            accept;
  logic [CNT_W-1:0]                wr_idx;

  // ---------------------------------------------------------------------------
  // Wakeup tag compare against every stored operand and the dispatching one.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit      = '0;
    disp_hit = '0;
    for (int w = 0; w < NUM_WAKEUP_PORTS; w++) begin
      for (int k = 0; k < NUM_SRCS; k++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wakeup_valid[w] && (wakeup_pdst[w*PREG_W +: PREG_W] == q[i].src_id[k]))
            hit[i][k] = 1'b1;
        end
        if (wakeup_valid[w] &&
            (wakeup_pdst[w*PREG_W +: PREG_W] == disp_src_id[k*PREG_W +: PREG_W]))
          disp_hit[k] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Readiness and oldest-first select. Entries at or above count are invalid
  // and are masked here, so stale contents can never be selected.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = (CNT_W'(i) < count);
      for (int k = 0; k < NUM_SRCS; k++) begin
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (q[i].src_v[k] && !(q[i].src_p[k] || hit[i][k])) rdy[i] = 1'b0;
`else
        if (q[i].src_v[k] && !q[i].src_p[k]) rdy[i] = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    // Scan downward so the lowest ready index wins.
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel     = IDX_W'(i);
        any_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    issue_valid  = any_rdy && !flush;
    fire         = issue_valid && issue_ready;
    issue_src_id = '0;
    issue_pdst   = '0;
    issue_ctrl   = '0;
    if (issue_valid) begin
      issue_src_id = q[sel].src_id;
      issue_pdst   = q[sel].pdst;
      issue_ctrl   = q[sel].ctrl;
    end
  end

  // disp_ready depends only on registered count: a full queue refuses
  // dispatch even when an entry fires in the same cycle.
  assign disp_ready = (count < CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;
  assign wr_idx     = count - CNT_W'(fire);

  // ---------------------------------------------------------------------------
  // Next state: collapse above the fired entry, then apply wakeups to the
  // shifted entries, then write the dispatched op at the new tail.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH-1; i++) begin
      if (fire && (IDX_W'(i) >= sel)) begin
        q_n[i]    = q[i+1];
        hit_sh[i] = hit[i+1];
      end else begin
        q_n[i]    = q[i];
        hit_sh[i] = hit[i];
      end
    end
    // Top slot has nothing above it; if it shifted down it becomes invalid.
    q_n[DEPTH-1]    = q[DEPTH-1];
    hit_sh[DEPTH-1] = hit[DEPTH-1];

    for (int i = 0; i < DEPTH; i++) begin
      q_n[i].src_p = q_n[i].src_p | (hit_sh[i] & q_n[i].src_v);
      if (accept && (CNT_W'(i) == wr_idx)) begin
        q_n[i].src_id = disp_src_id;
        q_n[i].src_p  = disp_src_p | disp_hit;
        q_n[i].src_v  = disp_src_v;
        q_n[i].pdst   = disp_pdst;
        q_n[i].ctrl   = disp_ctrl;
      end
    end

    if (flush) count_n = '0;
    else       count_n = count - CNT_W'(fire) + CNT_W'(accept);
  end

  // NOTE: entry storage is reset as well as count, so the issue buses and every
  // slot read as zero straight out of reset rather than holding X contents.
  // NOTE: state registers use non-blocking assignments so all entries sample
  // the same pre-edge values while shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      count <= count_n;
      for (int i = 0; i < DEPTH; i++) q[i] <= q_n[i];
    end
  end

endmodule
